// File: rtl/spwm_carrier_gen.sv
// Programmable-peak, prescaled sawtooth/triangle carrier with zero/peak strobes.
// Define CARRIER_SYNC_EN to add the sync_in phase-restart input.
module spwm_carrier_gen #(
    parameter int unsigned WIDTH   = 10,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode_in,
    input  logic [WIDTH-1:0]   peak_in,
    input  logic [PRESC_W-1:0] presc_in,
`ifdef CARRIER_SYNC_EN
    input  logic               sync_in,
`endif
    output logic [WIDTH-1:0]   carrier,
    output logic [WIDTH-1:0]   carrier_s,
    output logic               dir,
    output logic               zero_pulse,
    output logic               peak_pulse
);

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    dir_e               state,      state_nxt;
    logic [WIDTH-1:0]   carrier_nxt;
    logic [WIDTH-1:0]   carrier_s_nxt;
    logic               zero_nxt,   peak_nxt;
    logic [PRESC_W-1:0] presc_cnt,  presc_cnt_nxt;
    logic [WIDTH-1:0]   peak_s,     peak_s_nxt;
    logic [PRESC_W-1:0] presc_s,    presc_s_nxt;
    logic               mode_s,     mode_s_nxt;
    logic               step;

    assign dir = (state == DIR_UP);

    // State and output registers; shadows track the inputs while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DIR_UP;
            carrier    <= '0;
            carrier_s  <= MSB_MASK;
            zero_pulse <= 1'b0;
            peak_pulse <= 1'b0;
            presc_cnt  <= '0;
            peak_s     <= peak_in;
            presc_s    <= presc_in;
            mode_s     <= mode_in;
        end else begin
            state      <= state_nxt;
            carrier    <= carrier_nxt;
            carrier_s  <= carrier_s_nxt;
            zero_pulse <= zero_nxt;
            peak_pulse <= peak_nxt;
            presc_cnt  <= presc_cnt_nxt;
            peak_s     <= peak_s_nxt;
            presc_s    <= presc_s_nxt;
            mode_s     <= mode_s_nxt;
        end
    end

    // Prescaler, carrier step, strobes and shadow reload at the zero step.
    always_comb begin
        state_nxt     = state;
        carrier_nxt   = carrier;
        zero_nxt      = 1'b0;
        peak_nxt      = 1'b0;
        presc_cnt_nxt = presc_cnt;
        peak_s_nxt    = peak_s;
        presc_s_nxt   = presc_s;
        mode_s_nxt    = mode_s;
        step          = 1'b0;

        if (en) begin
            if (presc_cnt == presc_s) begin
                presc_cnt_nxt = '0;
                step          = 1'b1;
            end else begin
                presc_cnt_nxt = presc_cnt + PRESC_W'(1);
            end
        end

        if (step) begin
            if (peak_s == '0) begin
                carrier_nxt = '0;
                state_nxt   = DIR_UP;
            end else if (mode_s == 1'b0) begin
                carrier_nxt = (carrier == peak_s) ? '0 : carrier + WIDTH'(1);
                state_nxt   = DIR_UP;
            end else if (state == DIR_UP) begin
                if (carrier == peak_s) begin
                    carrier_nxt = peak_s - WIDTH'(1);
                    state_nxt   = DIR_DOWN;
                end else begin
                    carrier_nxt = carrier + WIDTH'(1);
                end
            end else begin
                if (carrier == '0) begin
                    carrier_nxt = WIDTH'(1);
                    state_nxt   = DIR_UP;
                end else begin
                    carrier_nxt = carrier - WIDTH'(1);
                end
            end

            zero_nxt = (carrier_nxt == '0);
            peak_nxt = (carrier_nxt == peak_s) && (peak_s != '0);

            // A period boundary: adopt new settings; a mode change restarts upward.
            if (carrier_nxt == '0) begin
                peak_s_nxt  = peak_in;
                presc_s_nxt = presc_in;
                mode_s_nxt  = mode_in;
                if (mode_in != mode_s) begin
                    state_nxt = DIR_UP;
                end
            end
        end

`ifdef CARRIER_SYNC_EN
        if (sync_in) begin
            carrier_nxt   = '0;
            state_nxt     = DIR_UP;
            presc_cnt_nxt = '0;
            peak_s_nxt    = peak_in;
            presc_s_nxt   = presc_in;
            mode_s_nxt    = mode_in;
            zero_nxt      = 1'b1;
            peak_nxt      = 1'b0;
        end
`endif

        carrier_s_nxt = carrier_nxt ^ MSB_MASK;
    end

endmodule
